fp_add_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing one pipelined single-precision float_adder between MAC lanes.
- Registers the granted operand pair onto the adder inputs and tracks ownership of each in-flight operation with a tag shift register.
- Returns each adder result to the lane that issued it.
- Per-lane credit counters bound outstanding operations.

---
 rtl/fp_mac_pkg.sv | 20 ++
 rtl/fp_add_arbiter_chk.sv | 19 +
 rtl/fp_add_arbiter_rr_arb2.sv | 51 +++++
 rtl/fp_add_arbiter.sv | 141 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mac_pkg.sv
// Shared types and defaults for the MAC lanes that share one float adder.
package fp_mac_pkg;

  localparam int FP_W            = 32;
  localparam int LANE_W          = 1;
  localparam int DEF_ADD_LATENCY = 6;
  localparam int DEF_MAX_OUT     = 4;

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, lane: 1'b0};

  function automatic tag_t make_tag(input logic [LANE_W-1:0] lane);
    make_tag = '{valid: 1'b1, lane: lane};
  endfunction

endpackage

// File: rtl/fp_add_arbiter_chk.sv
// Invariant checks for the outstanding-operation counters.
module fp_add_arbiter_chk #(
  parameter int CNT_W = 3
) (
  input logic             clock,
  input logic             reset,
  input logic             ret0_i,
  input logic             ret1_i,
  input logic [CNT_W-1:0] cnt0_i,
  input logic [CNT_W-1:0] cnt1_i
);

  a_ret0_has_credit: assert property (@(posedge clock) disable iff (reset)
    !(ret0_i && (cnt0_i == '0)));

  a_ret1_has_credit: assert property (@(posedge clock) disable iff (reset)
    !(ret1_i && (cnt1_i == '0)));

endmodule

// File: rtl/fp_add_arbiter_rr_arb2.sv
// Two-way round-robin grant; the remembered lane loses the next tie.
module rr_arb2 import fp_mac_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        elig_i,
  output logic              gnt_valid_o,
  output logic [LANE_W-1:0] gnt_lane_o
);

  logic [LANE_W-1:0] last_q;
  logic [LANE_W-1:0] last_d;

  // Grant selection and last-grant update
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_lane_o  = 1'b0;
    case (elig_i)
      2'b01: begin
        gnt_valid_o = 1'b1;
        gnt_lane_o  = 1'b0;
      end
      2'b10: begin
        gnt_valid_o = 1'b1;
        gnt_lane_o  = 1'b1;
      end
      2'b11: begin
        gnt_valid_o = 1'b1;
        gnt_lane_o  = ~last_q;
      end
      default: begin
        gnt_valid_o = 1'b0;
        gnt_lane_o  = 1'b0;
      end
    endcase
    if (gnt_valid_o) begin
      last_d = gnt_lane_o;
    end else begin
      last_d = last_q;
    end
  end

  // Lane 1 is remembered out of reset so lane 0 wins the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined float adder between two MAC lanes and routes each
// result back to its issuer using a tag pipeline that mirrors the adder.
module fp_add_arbiter import fp_mac_pkg::*; #(
  parameter int ADD_LATENCY = DEF_ADD_LATENCY,
  parameter int MAX_OUT     = DEF_MAX_OUT,
  parameter int CNT_W       = $clog2(MAX_OUT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [FP_W-1:0]  req0_a,
  input  logic [FP_W-1:0]  req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [FP_W-1:0]  req1_a,
  input  logic [FP_W-1:0]  req1_b,
  output logic             req1_ready,
  output logic [FP_W-1:0]  add_a,
  output logic [FP_W-1:0]  add_b,
  input  logic [FP_W-1:0]  add_result,
  output logic [FP_W-1:0]  rsp_data,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [CNT_W-1:0] out0,
  output logic [CNT_W-1:0] out1,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [FP_W-1:0]   add_a_q, add_a_d;
  logic [FP_W-1:0]   add_b_q, add_b_d;
  tag_t              tag_q [ADD_LATENCY];
  tag_t              tag0_d;
  tag_t              tag_out;
  logic [CNT_W-1:0]  out0_q, out0_d;
  logic [CNT_W-1:0]  out1_q, out1_d;
  logic              rsp0_q, rsp1_q;
  logic              gnt_valid;
  logic [LANE_W-1:0] gnt_lane;
  logic              ret0, ret1;
  logic              tags_busy;

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   next_count = cnt + CNT_W'(1);
      2'b01:   next_count = cnt - CNT_W'(1);
      default: next_count = cnt;
    endcase
  endfunction

  rr_arb2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .elig_i      ({req1_valid && (out1_q < MAX_CNT), req0_valid && (out0_q < MAX_CNT)}),
    .gnt_valid_o (gnt_valid),
    .gnt_lane_o  (gnt_lane)
  );

  assign req0_ready = gnt_valid && (gnt_lane == 1'b0);
  assign req1_ready = gnt_valid && (gnt_lane == 1'b1);

  // The entry leaving the last tag stage lines up with add_result one cycle later
  assign tag_out = tag_q[ADD_LATENCY-1];
  assign ret0    = tag_out.valid && (tag_out.lane == 1'b0);
  assign ret1    = tag_out.valid && (tag_out.lane == 1'b1);

  // Operand capture and issue tag for the granted lane
  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    tag0_d  = TAG_NONE;
    if (req1_ready) begin
      add_a_d = req1_a;
      add_b_d = req1_b;
      tag0_d  = make_tag(1'b1);
    end else if (req0_ready) begin
      add_a_d = req0_a;
      add_b_d = req0_b;
      tag0_d  = make_tag(1'b0);
    end else begin
      tag0_d  = TAG_NONE;
    end
  end

  // Credit bookkeeping and in-flight detection
  always_comb begin
    out0_d    = next_count(out0_q, req0_ready, ret0);
    out1_d    = next_count(out1_q, req1_ready, ret1);
    tags_busy = 1'b0;
    for (int i = 0; i < ADD_LATENCY; i++) begin
      tags_busy = tags_busy | tag_q[i].valid;
    end
  end

  // Pipeline, counter and response state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      add_a_q <= '0;
      add_b_q <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) begin
        tag_q[i] <= TAG_NONE;
      end
      out0_q  <= '0;
      out1_q  <= '0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      tag_q[0] <= tag0_d;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      rsp0_q   <= ret0;
      rsp1_q   <= ret1;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp_data   = add_result;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign out0       = out0_q;
  assign out1       = out1_q;
  assign busy       = req0_ready | req1_ready | tags_busy | rsp0_q | rsp1_q;

  fp_add_arbiter_chk #(.CNT_W(CNT_W)) u_chk (
    .clock  (clock),
    .reset  (reset),
    .ret0_i (ret0),
    .ret1_i (ret1),
    .cnt0_i (out0_q),
    .cnt1_i (out1_q)
  );

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural adder, vector table and response scoreboard.
module tb_fp_add_arbiter;

  localparam int LAT  = 6;
  localparam int MAXO = 4;
  localparam int CW   = 3;
  localparam int NV   = 35;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0]   req0_a, req0_b, req1_a, req1_b;
  logic [31:0]   add_a, add_b, add_result, rsp_data;
  logic          rsp0_valid, rsp1_valid, busy;
  logic [CW-1:0] out0, out1;

  always #5 clock = ~clock;

  fp_add_arbiter #(.ADD_LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_data(rsp_data), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .out0(out0), .out1(out1), .busy(busy)
  );

  // Positive-normal float add (truncating), enough for the operands used here
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [7:0]  ea, d;
    logic [24:0] ma, mb, s;
    if (x[30:23] >= y[30:23]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ea = a[30:23];
    d  = a[30:23] - b[30:23];
    ma = {2'b01, a[22:0]};
    mb = {2'b01, b[22:0]};
    mb = (d > 8'd24) ? 25'd0 : (mb >> d);
    s  = ma + mb;
    if (s[24]) begin s = s >> 1; ea = ea + 8'd1; end
    return {1'b0, ea, s[22:0]};
  endfunction

  logic [31:0] apipe [LAT];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) apipe[i] <= 32'd0;
    end else begin
      apipe[0] <= fadd(add_a, add_b);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign add_result = apipe[LAT-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        lane;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor: every pulse must match the oldest expected issue
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (rsp0_valid || rsp1_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b data=%h at cycle %0d, expected none",
                   rsp0_valid, rsp1_valid, rsp_data, cyc);
        end else begin
          e = sb.pop_front();
          if (rsp0_valid == !e.lane && rsp1_valid == e.lane && rsp_data === e.data && cyc == e.cyc)
            n_pass++;
          else
            $display("FAIL rsp: got rsp0=%b rsp1=%b data=%h cycle=%0d, expected lane=%0d data=%h cycle=%0d",
                     rsp0_valid, rsp1_valid, rsp_data, cyc, e.lane, e.data, e.cyc);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        n_checks++;
        e = sb.pop_front();
        $display("FAIL rsp_missing: got no pulse at cycle %0d, expected lane=%0d data=%h",
                 cyc, e.lane, e.data);
      end
    end
  end

  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic r0, input logic r1,
                      input logic [31:0] s0, input logic [31:0] s1);
    @(posedge clock); #1;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    @(negedge clock);
    chk("ready0", {31'd0, req0_ready}, {31'd0, r0});
    chk("ready1", {31'd0, req1_ready}, {31'd0, r1});
    if (r0) sb.push_back('{data: s0, lane: 1'b0, cyc: cyc + LAT + 1});
    if (r1) sb.push_back('{data: s1, lane: 1'b1, cyc: cyc + LAT + 1});
  endtask

  task automatic idle_cycle();
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle_cycle();
    while (sb.size() != 0 && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [31:0] a1, b1;
    logic        r0, r1;
    logic [31:0] s0, s1;
  } vec_t;
  vec_t tbl [NV];

  int ov [14] = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 3, 3, 4, 4, 4};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    logic fair, l0, l1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0;

    // Rows 0-3 tie; rows 12-26 lane 1 saturates credit; rows 16-18 lane 0 alone eligible
    for (int i = 0; i < NV; i++) begin
      fair = (i < 4);
      l1   = (i >= 12) && (i <= 26);
      l0   = (i >= 16) && (i <= 18);
      tbl[i].v0 = fair || l0;
      tbl[i].a0 = fair ? 32'h3FC00000 : (32'h40400000 | (32'(i) << 15));
      tbl[i].b0 = fair ? 32'h3FC00000 : 32'h3F800000;
      tbl[i].v1 = fair || l1;
      tbl[i].a1 = fair ? 32'h40000000 : (32'h3F800000 | (32'(i) << 16));
      tbl[i].b1 = 32'h40000000;
      tbl[i].r0 = fair ? (i % 2 == 0) : l0;
      tbl[i].r1 = fair ? (i % 2 == 1)
                       : (l1 && ((i <= 15) || (i >= 19 && i <= 22) || (i == 26)));
      tbl[i].s0 = fair ? 32'h40400000 : fadd(tbl[i].a0, tbl[i].b0);
      tbl[i].s1 = fair ? 32'h40800000 : fadd(tbl[i].a1, tbl[i].b1);
    end

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_out0", {29'd0, out0}, 32'd0);
    chk("rst_out1", {29'd0, out1}, 32'd0);
    chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < NV; i++)
      step(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1,
           tbl[i].r0, tbl[i].r1, tbl[i].s0, tbl[i].s1);
    drain();

    // Single lane-0 op: counter returns to zero on the response cycle
    step(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h40400000, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      idle_cycle();
      @(negedge clock);
      chk("single_out0", {29'd0, out0}, (k <= 6) ? 32'd1 : 32'd0);
      if (k == 3) chk("single_busy", {31'd0, busy}, 32'd1);
      if (k == 9) chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Lane 0 streaming against its credit limit
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 32'h3F800000 | (32'(k) << 17), 32'h3F800000, 1'b0, 32'd0, 32'd0,
           (k % 7) < 4, 1'b0, fadd(32'h3F800000 | (32'(k) << 17), 32'h3F800000), 32'd0);
      chk("stream_out0", {29'd0, out0}, 32'(ov[k]));
    end
    drain();

    // Reset with three lane-0 ops in flight
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h40800000, 32'd0);
    for (int k = 3; k < 7; k++) idle_cycle();
    @(posedge clock); #1;
    chk("pre_reset_rsp0", {31'd0, rsp0_valid}, 32'd1);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("async_rst_out0", {29'd0, out0}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_add_a", add_a, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("no_stale_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end

    // Tie right after reset goes to lane 0 first
    step(1'b1, 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40000000, 32'h40000000,
         1'b1, 1'b0, 32'h40400000, 32'h40800000);
    step(1'b1, 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40000000, 32'h40000000,
         1'b0, 1'b1, 32'h40400000, 32'h40800000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
